// File: rtl/wb_retire_stage_pkg.sv
// Shared core definitions for the write-back / retire stage: flush-kind encodings,
// the control part of a retire-buffer entry record, and the default CSR number width.
package wb_retire_stage_pkg;

    localparam int unsigned CSR_NUM_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        FlushNone    = 2'b00,
        FlushExc     = 2'b01,
        FlushErtn    = 2'b10,
        FlushRefetch = 2'b11
    } flush_kind_e;

    // Width-independent control fields of an entry record; the DATA_W / CSR_NUM_W
    // payload (pc, result, csr number, csr write data) is appended by the stage.
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic        csr_re;
        logic        csr_we;
        flush_kind_e flush_kind;
    } entry_ctrl_t;

    // An excepting instruction never touches the CSR file.
    function automatic logic needs_csr(input entry_ctrl_t ctrl);
        return (ctrl.csr_re || ctrl.csr_we) && (ctrl.flush_kind != FlushExc);
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// In-order circular retire buffer with per-entry valid bits, wrapping head/tail
// pointers and an occupancy counter. A flush empties the buffer in one edge.
module retire_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next-state for pointers, valid bits and occupancy; flush wins over push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            count_d = '0;
        end else begin
            // Pop before push so a full buffer can refill the slot it frees.
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (push) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign head_valid = valid_q[head_q];
    assign head_data  = mem_q[head_q];
    assign occupancy  = count_q;

endmodule

// File: rtl/wb_retire_stage.sv
// Write-back / retire stage: buffers instructions from MEM in order, performs the
// CSR handshake for the head entry, writes the GPR file and raises pipeline flushes.
// Optional feature: define WB_RETIRE_DEBUG_EN to add the debug_wb_* trace outputs.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CSR_NUM_W = CSR_NUM_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ms2ws_valid,
    output logic                     ws_allowin,
    input  logic [DATA_W-1:0]        ms_pc,
    input  logic                     ms_gr_we,
    input  logic [4:0]               ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic                     ms_csr_re,
    input  logic                     ms_csr_we,
    input  logic [CSR_NUM_W-1:0]     ms_csr_num,
    input  logic [DATA_W-1:0]        ms_csr_wdata,
    input  logic [1:0]               ms_flush_kind,
    output logic                     csr_req,
    output logic [CSR_NUM_W-1:0]     csr_num,
    output logic                     csr_we,
    output logic [DATA_W-1:0]        csr_wdata,
    input  logic                     csr_ready,
    input  logic [DATA_W-1:0]        csr_rvalue,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     ws_reflush,
    output logic [1:0]               ws_flush_kind,
    output logic [DATA_W-1:0]        ws_flush_pc,
    output logic [$clog2(DEPTH):0]   ws_occupancy
`ifdef WB_RETIRE_DEBUG_EN
    ,
    output logic [DATA_W-1:0]        debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata
`endif
);

    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
    localparam int unsigned CTRL_W  = $bits(entry_ctrl_t);
    localparam int unsigned ENTRY_W = CTRL_W + 3 * DATA_W + CSR_NUM_W;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    entry_ctrl_t          in_ctrl;
    entry_ctrl_t          head_ctrl;
    logic [ENTRY_W-1:0]   in_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [DATA_W-1:0]    head_pc;
    logic [DATA_W-1:0]    head_result;
    logic [DATA_W-1:0]    head_csr_wdata;
    logic [CSR_NUM_W-1:0] head_csr_num;
    logic                 head_valid;
    logic                 retire;
    logic                 flush;
    logic                 accept;
    logic [OCC_W-1:0]     occupancy;

    // Pack the incoming MEM-stage fields into one entry record.
    always_comb begin
        in_ctrl.gr_we      = ms_gr_we;
        in_ctrl.dest       = ms_dest;
        in_ctrl.csr_re     = ms_csr_re;
        in_ctrl.csr_we     = ms_csr_we;
        in_ctrl.flush_kind = flush_kind_e'(ms_flush_kind);
        in_entry           = {in_ctrl, ms_pc, ms_result, ms_csr_num, ms_csr_wdata};
    end

    assign {head_ctrl, head_pc, head_result, head_csr_num, head_csr_wdata} = head_entry;

    retire_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_retire_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_data  (in_entry),
        .pop        (retire),
        .flush      (flush),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .occupancy  (occupancy)
    );

    // Retire/flush control: head handshake, back-pressure and flush decision.
    always_comb begin
        csr_req    = head_valid && needs_csr(head_ctrl);
        retire     = head_valid && (!csr_req || csr_ready);
        flush      = retire && (head_ctrl.flush_kind != FlushNone);
        // A full buffer still accepts when the head leaves, unless that exit flushes.
        ws_allowin = !flush && ((occupancy < FULL_CNT) || retire);
        accept     = ms2ws_valid && ws_allowin;
    end

    // Register-file write and CSR request payload from the head entry.
    always_comb begin
        rf_we     = retire && head_ctrl.gr_we && (head_ctrl.flush_kind != FlushExc);
        rf_waddr  = head_ctrl.dest;
        rf_wdata  = head_ctrl.csr_re ? csr_rvalue : head_result;
        csr_num   = head_csr_num;
        csr_we    = head_ctrl.csr_we;
        csr_wdata = head_csr_wdata;
    end

    // Flush pulse follows the retiring head; kind reads as none when idle.
    always_comb begin
        ws_reflush    = flush;
        ws_flush_kind = flush ? head_ctrl.flush_kind : FlushNone;
        ws_flush_pc   = head_pc;
    end

    assign ws_occupancy = occupancy;

`ifdef WB_RETIRE_DEBUG_EN
    // Trace of the instruction retiring this cycle.
    always_comb begin
        debug_wb_pc       = head_pc;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end
`endif

endmodule
